instruction_fetch: RTL and testbench

Fetch stage of the MIPS core. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It holds the returned instruction and drives Opcode/FuncCode to `SingleCycleControl` and the full instruction word to the datapath. When the datapath signals completion, it computes the next PC from the Jump, Branch and Zero results of the current instruction.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch_next_pc_calc.sv | 41 ++++
 rtl/instruction_fetch.sv | 114 +++++++++++
 tb/tb_instruction_fetch.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS core. Holds the fetch-stage
//                state encoding, the instruction field positions and the
//                opcode constants also used by SingleCycleControl.
//                Also holds the branch offset helper used by next_pc_calc.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int JIDX_MSB   = 25;
    localparam int IMM_MSB    = 15;

    // Opcodes shared with the control unit
    localparam logic [5:0] JOPCODE   = 6'h02;
    localparam logic [5:0] BEQOPCODE = 6'h04;

    // Word-scaled, sign-extended branch displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
//  Module      : instruction_fetch_if
//  Description : Instruction-memory read channel (req/ack handshake).
//                master : fetch stage  (drives IMemReq, IMemAddr)
//                slave  : memory side  (drives IMemAck, IMemData)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemData
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_next_pc_calc.sv
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC selection: PC+4, beq target or
//                j target. Jump has priority over a taken branch.
//  Ports       : pc_i          current PC
//                instr_idx_i   Instr[25:0] (jump index, low half = imm)
//                jump_i        jump from control
//                branch_i      branch from control
//                zero_i        ALU zero flag
//                pc_plus4_o    pc_i + 4 (wraps modulo 2^32)
//                next_pc_o     selected next PC
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
    import mips_pkg::*;
(
    input  wire  [31:0]       pc_i,
    input  wire  [JIDX_MSB:0] instr_idx_i,
    input  wire               jump_i,
    input  wire               branch_i,
    input  wire               zero_i,
    output logic [31:0]       pc_plus4_o,
    output logic [31:0]       next_pc_o
);

    assign pc_plus4_o = pc_i + 32'd4;

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], instr_idx_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_o = pc_plus4_o + branch_offset(instr_idx_i[IMM_MSB:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
//  Module      : instruction_fetch
//  Description : MIPS fetch stage. Owns the PC, reads instruction memory over
//                a req/ack handshake, holds the returned word for decode and
//                steps the PC when the datapath retires the instruction.
//  Config      : IFETCH_ALIGN_CHECK_EN - when defined, a misaligned next PC
//                traps into FAULT (left only by reset). When undefined, the
//                next PC is forced word-aligned and Fault is tied 0.
//  Ports       : CLK, Resetb (async, active low)
//                imem        instruction memory channel (master)
//                Instr/Opcode/FuncCode/InstrValid  held instruction + decode
//                PC, PCPlus4 address of held instruction and its successor
//                Advance, Jump, Branch, Zero       retire + flow control
//                Fault       misaligned-target trap
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire                 CLK,
    input  wire                 Resetb,
    instruction_fetch_if.master imem,
    output logic [31:0]         Instr,
    output logic [5:0]          Opcode,
    output logic [5:0]          FuncCode,
    output logic                InstrValid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    input  wire                 Advance,
    input  wire                 Jump,
    input  wire                 Branch,
    input  wire                 Zero,
    output logic                Fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc_raw;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc_calc (
        .pc_i        (pc_q),
        .instr_idx_i (instr_q[JIDX_MSB:0]),
        .jump_i      (Jump),
        .branch_i    (Branch),
        .zero_i      (Zero),
        .pc_plus4_o  (PCPlus4),
        .next_pc_o   (next_pc_raw)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    assign next_pc    = next_pc_raw;
    assign misaligned = (next_pc_raw[1:0] != 2'b00);
    assign Fault      = (state_q == FAULT);
`else
    assign next_pc    = next_pc_raw & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
    assign Fault      = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem.IMemAck) begin
                    instr_d = imem.IMemData;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (Advance) begin
                    // PC takes the target even when it traps, for post-mortem
                    pc_d    = next_pc;
                    state_d = misaligned ? FAULT : REQ;
                end
            end
            default: state_d = state_q;   // FAULT: only reset leaves
        endcase
    end

    // Request and valid decode straight from the state register so an async
    // reset drops them immediately.
    assign imem.IMemReq  = (state_q == REQ);
    assign imem.IMemAddr = pc_q;
    assign InstrValid    = (state_q == HOLD);
    assign PC            = pc_q;
    assign Instr         = instr_q;
    assign Opcode        = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign FuncCode      = instr_q[FUNC_MSB:FUNC_LSB];

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Scoreboard bench for instruction_fetch. Three instances:
//                A (RESET_PC=0) runs the directed fetch sequence,
//                B (RESET_PC=0x4000_0010) checks jump-over-branch priority,
//                C (RESET_PC=0x2) checks the misaligned-target behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } hold_t;

    // Instruction memory contents used by all instances
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000, 32'h0000_0100: return 32'h1000_FFFE;  // beq imm=-2
            32'h0000_0008, 32'h4000_0010: return 32'h0800_0040;  // j 0x40
            32'h0000_0108:                return 32'h1000_0010;  // beq imm=16
            default:                      return {16'h2000, a[15:0]};
        endcase
    endfunction

    logic CLK = 1'b0;
    logic Resetb;
    always #5 CLK = ~CLK;

    logic ack_a, adv_a, jmp_a, br_a, zero_a, adv2;

    instruction_fetch_if ifa ();
    instruction_fetch_if ifb ();
    instruction_fetch_if ifc ();

    assign ifa.IMemAck  = ack_a;
    assign ifa.IMemData = mem_word(ifa.IMemAddr);
    assign ifb.IMemAck  = 1'b1;
    assign ifb.IMemData = mem_word(ifb.IMemAddr);
    assign ifc.IMemAck  = 1'b1;
    assign ifc.IMemData = mem_word(ifc.IMemAddr);

    logic [31:0] instr_a, pc_a, pc4_a, instr_b, pc_b, pc4_b, instr_c, pc_c, pc4_c;
    logic [5:0]  opc_a, fn_a, opc_b, fn_b, opc_c, fn_c;
    logic        valid_a, fault_a, valid_b, fault_b, valid_c, fault_c;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .CLK(CLK), .Resetb(Resetb), .imem(ifa.master),
        .Instr(instr_a), .Opcode(opc_a), .FuncCode(fn_a), .InstrValid(valid_a),
        .PC(pc_a), .PCPlus4(pc4_a), .Advance(adv_a), .Jump(jmp_a),
        .Branch(br_a), .Zero(zero_a), .Fault(fault_a)
    );

    instruction_fetch #(.RESET_PC(32'h4000_0010)) u_dut_b (
        .CLK(CLK), .Resetb(Resetb), .imem(ifb.master),
        .Instr(instr_b), .Opcode(opc_b), .FuncCode(fn_b), .InstrValid(valid_b),
        .PC(pc_b), .PCPlus4(pc4_b), .Advance(adv2), .Jump(1'b1),
        .Branch(1'b1), .Zero(1'b1), .Fault(fault_b)
    );

    instruction_fetch #(.RESET_PC(32'h0000_0002)) u_dut_c (
        .CLK(CLK), .Resetb(Resetb), .imem(ifc.master),
        .Instr(instr_c), .Opcode(opc_c), .FuncCode(fn_c), .InstrValid(valid_c),
        .PC(pc_c), .PCPlus4(pc4_c), .Advance(adv2), .Jump(1'b0),
        .Branch(1'b0), .Zero(1'b0), .Fault(fault_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] exp_addr_q[$];
    hold_t       exp_hold_q[$];
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;

    always @(negedge CLK) begin
        hold_t h;
        if (ifa.IMemReq && !prev_req) begin
            if (exp_addr_q.size() == 0) fail_now("sb_unexpected_req");
            else chk("sb_req_addr", ifa.IMemAddr, exp_addr_q.pop_front());
        end
        if (valid_a && !prev_valid) begin
            if (exp_hold_q.size() == 0) fail_now("sb_unexpected_valid");
            else begin
                h = exp_hold_q.pop_front();
                chk("sb_hold_pc", pc_a, h.pc);
                chk("sb_hold_instr", instr_a, h.instr);
                chk("sb_opcode", {26'b0, opc_a}, {26'b0, h.instr[31:26]});
                chk("sb_funccode", {26'b0, fn_a}, {26'b0, h.instr[5:0]});
            end
        end
        prev_req   = ifa.IMemReq;
        prev_valid = valid_a;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] cur_pc;
    logic [31:0] last_instr;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for the request, stall the ack d cycles (with a stray Advance),
    // then ack and expect the held instruction next cycle.
    task automatic do_fetch(input int d);
        int n = 0;
        while (!ifa.IMemReq && n < 10) begin
            tick();
            n++;
        end
        if (!ifa.IMemReq) fail_now("fetch_timeout");
        for (int k = 0; k < d; k++) begin
            ack_a = 1'b0;
            adv_a = 1'b1;
            tick();
            chk("wait_req", {31'b0, ifa.IMemReq}, 32'd1);
            chk("wait_addr", ifa.IMemAddr, cur_pc);
            chk("wait_instr", instr_a, last_instr);
        end
        adv_a = 1'b0;
        chk("pcplus4", pc4_a, cur_pc + 32'd4);
        exp_hold_q.push_back('{pc: cur_pc, instr: mem_word(cur_pc)});
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        last_instr = mem_word(cur_pc);
        chk("ack_latency_valid", {31'b0, valid_a}, 32'd1);
        chk("hold_req_low", {31'b0, ifa.IMemReq}, 32'd0);
    endtask

    task automatic do_adv(input logic j, input logic b, input logic z, input logic [31:0] nxt);
        jmp_a  = j;
        br_a   = b;
        zero_a = z;
        adv_a  = 1'b1;
        exp_addr_q.push_back(nxt);
        tick();
        adv_a  = 1'b0;
        jmp_a  = 1'b0;
        br_a   = 1'b0;
        zero_a = 1'b0;
        chk("adv_valid_drop", {31'b0, valid_a}, 32'd0);
        chk("adv_req", {31'b0, ifa.IMemReq}, 32'd1);
        chk("adv_addr", ifa.IMemAddr, nxt);
        cur_pc = nxt;
    endtask

    task automatic run_vec(input int d, input logic j, input logic b, input logic z,
                           input logic [31:0] nxt);
        do_fetch(d);
        do_adv(j, b, z, nxt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetb = 1'b0;
        ack_a  = 1'b0;
        adv_a  = 1'b0;
        jmp_a  = 1'b0;
        br_a   = 1'b0;
        zero_a = 1'b0;
        adv2   = 1'b0;
        last_instr = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_valid", {31'b0, valid_a}, 32'd0);
        chk("rst_req", {31'b0, ifa.IMemReq}, 32'd0);
        chk("rst_fault", {31'b0, fault_a}, 32'd0);

        // Ack tied high from release: request in cycle 1, valid in cycle 2
        cur_pc = 32'h0;
        exp_addr_q.push_back(32'h0);
        ack_a  = 1'b1;
        Resetb = 1'b1;
        tick();
        chk("c1_req", {31'b0, ifa.IMemReq}, 32'd1);
        chk("c1_addr", ifa.IMemAddr, 32'h0);

        run_vec(0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
        run_vec(0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
        run_vec(3, 1'b1, 1'b0, 1'b0, 32'h0000_0100);   // j 0x40
        run_vec(0, 1'b0, 1'b1, 1'b1, 32'h0000_00FC);   // beq -2 taken
        run_vec(1, 1'b0, 1'b0, 1'b0, 32'h0000_0100);
        run_vec(0, 1'b0, 1'b1, 1'b0, 32'h0000_0104);   // beq not taken
        run_vec(0, 1'b0, 1'b0, 1'b1, 32'h0000_0108);   // Zero without Branch
        run_vec(2, 1'b0, 1'b1, 1'b1, 32'h0000_014C);   // beq +16 taken
        run_vec(0, 1'b0, 1'b0, 1'b0, 32'h0000_0150);

        // Reset in the middle of a pending request
        ack_a = 1'b0;
        tick();
        Resetb = 1'b0;
        #1;
        chk("midrst_req", {31'b0, ifa.IMemReq}, 32'd0);
        chk("midrst_valid", {31'b0, valid_a}, 32'd0);
        chk("midrst_pc", pc_a, 32'h0);
        ack_a = 1'b1;                                   // late ack
        tick();
        chk("midrst_req_held", {31'b0, ifa.IMemReq}, 32'd0);
        cur_pc     = 32'h0;
        last_instr = 32'h0;
        exp_addr_q.push_back(32'h0);
        Resetb = 1'b1;
        tick();
        chk("late_ack_req", {31'b0, ifa.IMemReq}, 32'd1);
        chk("late_ack_valid", {31'b0, valid_a}, 32'd0);
        chk("late_ack_instr", instr_a, 32'h0);

        run_vec(0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);   // 0 + 4 - 8 wraps
        run_vec(0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);   // FFFF_FFFC + 4 wraps

        // Hold with stray acks: nothing may change
        do_fetch(0);
        ack_a = 1'b1;
        repeat (3) tick();
        ack_a = 1'b0;
        chk("hold_pc", pc_a, 32'h0);
        chk("hold_instr", instr_a, 32'h1000_FFFE);
        chk("hold_valid", {31'b0, valid_a}, 32'd1);
        chk("hold_req", {31'b0, ifa.IMemReq}, 32'd0);

        // Instance B: Jump and Branch both asserted, Jump wins
        chk("b_pc", pc_b, 32'h4000_0010);
        chk("b_instr", instr_b, 32'h0800_0040);
        chk("b_opcode", {26'b0, opc_b}, 32'h02);
        chk("b_func", {26'b0, fn_b}, 32'h00);
        chk("b_pc4", pc4_b, 32'h4000_0014);
        chk("b_valid", {31'b0, valid_b}, 32'd1);
        chk("b_fault", {31'b0, fault_b}, 32'd0);
        // Instance C: misaligned reset PC
        chk("c_instr", instr_c, 32'h2000_0002);
        chk("c_opcode", {26'b0, opc_c}, 32'h08);
        chk("c_func", {26'b0, fn_c}, 32'h02);
        chk("c_pc4", pc4_c, 32'h0000_0006);
        chk("c_valid", {31'b0, valid_c}, 32'd1);
        adv2 = 1'b1;
        tick();
        adv2 = 1'b0;
        chk("b_jump_addr", ifb.IMemAddr, 32'h4000_0100);
        chk("b_jump_req", {31'b0, ifb.IMemReq}, 32'd1);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("c_fault", {31'b0, fault_c}, 32'd1);
        chk("c_pc", pc_c, 32'h0000_0006);
        chk("c_valid_off", {31'b0, valid_c}, 32'd0);
        repeat (3) tick();
        chk("c_req_off", {31'b0, ifc.IMemReq}, 32'd0);
        chk("c_fault_sticky", {31'b0, fault_c}, 32'd1);
`else
        chk("c_fault", {31'b0, fault_c}, 32'd0);
        chk("c_pc_aligned", pc_c, 32'h0000_0004);
        chk("c_req", {31'b0, ifc.IMemReq}, 32'd1);
        chk("c_addr", ifc.IMemAddr, 32'h0000_0004);
`endif

        tick();
        chk("sb_addr_drained", exp_addr_q.size(), 32'd0);
        chk("sb_hold_drained", exp_hold_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
